// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE sequencer slice.
//   DATA_W : operand / psum width of the PE datapath
//   MAX_S  : scratchpad depth, i.e. the maximum number of filter taps
//   E_W    : width of the output-count field
//   CNT_W  : width able to hold 0..MAX_S (tap count S)
//   PTR_W  : scratchpad address width (0..MAX_S-1)
package pe_pkg;

    localparam int DATA_W = 16;
    localparam int MAX_S  = 16;
    localparam int E_W    = 8;
    localparam int CNT_W  = $clog2(MAX_S + 1);
    localparam int PTR_W  = (MAX_S > 1) ? $clog2(MAX_S) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_I,
        MAC,
        OUT,
        SLIDE
    } state_t;

endpackage

// File: rtl/pe_spad.sv
// Small register-file scratchpad: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module pe_spad #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one MAC processing element computing a 1-D convolution row.
// Loads S filter taps and an S-word ifmap window, then for each of E outputs
// streams S taps into the PE (feeding back its registered psum), returns the
// result on the ps stream and slides the window by one ifmap word.
//   clk, rst_n                    : clock, async active-low reset
//   start, cfg_s, cfg_e           : job request with tap count S and output count E
//   busy, done                    : job in progress / one-cycle end-of-job pulse
//   flt_valid/flt_ready/flt_data  : filter word stream in
//   if_valid/if_ready/if_data     : ifmap word stream in
//   pe_en, pe_ifmap, pe_filter,
//   pe_psum_in                    : PE operand drive (zeroed when pe_en is low)
//   pe_psum                       : PE registered result
//   ps_valid/ps_ready/ps_data     : finished output stream
module pe_seq_ctrl #(
    parameter int DATA_W = pe_pkg::DATA_W,
    parameter int MAX_S  = pe_pkg::MAX_S,
    parameter int E_W    = pe_pkg::E_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(MAX_S+1)-1:0] cfg_s,
    input  logic [E_W-1:0]             cfg_e,
    output logic                       busy,
    output logic                       done,
    input  logic                       flt_valid,
    output logic                       flt_ready,
    input  logic [DATA_W-1:0]          flt_data,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [DATA_W-1:0]          if_data,
    output logic                       pe_en,
    output logic [DATA_W-1:0]          pe_ifmap,
    output logic [DATA_W-1:0]          pe_filter,
    output logic [DATA_W-1:0]          pe_psum_in,
    input  logic [DATA_W-1:0]          pe_psum,
    output logic                       ps_valid,
    input  logic                       ps_ready,
    output logic [DATA_W-1:0]          ps_data
);

    import pe_pkg::*;

    localparam int SW = $clog2(MAX_S + 1);
    localparam int PW = (MAX_S > 1) ? $clog2(MAX_S) : 1;

    state_t          state, state_n;
    logic [SW-1:0]   s_reg, s_n;
    logic [E_W-1:0]  e_rem, e_n;
    logic [PW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   head, head_n;
    logic            done_n;

    logic [SW-1:0]   s_clamp;
    logic            last_tap;
    logic [SW-1:0]   to_end;
    logic [PW-1:0]   win_raddr;
    logic [PW-1:0]   win_waddr;
    logic            flt_we, win_we;
    logic [DATA_W-1:0] flt_rd, win_rd;

    assign s_clamp  = (cfg_s > SW'(MAX_S)) ? SW'(MAX_S) : cfg_s;
    assign last_tap = (cnt == PW'(s_reg - 1'b1));

    // (head + k) mod S without a wider adder: wrap once k reaches S - head.
    assign to_end    = s_reg - SW'(head);
    assign win_raddr = (SW'(cnt) >= to_end) ? PW'(SW'(cnt) - to_end) : (head + cnt);

    assign flt_we    = (state == LOAD_F) && flt_valid;
    assign win_we    = ((state == LOAD_I) || (state == SLIDE)) && if_valid;
    assign win_waddr = (state == SLIDE) ? head : cnt;

    pe_spad #(
        .DEPTH (MAX_S),
        .WIDTH (DATA_W),
        .AW    (PW)
    ) u_flt_spad (
        .clk   (clk),
        .we    (flt_we),
        .waddr (cnt),
        .wdata (flt_data),
        .raddr (cnt),
        .rdata (flt_rd)
    );

    pe_spad #(
        .DEPTH (MAX_S),
        .WIDTH (DATA_W),
        .AW    (PW)
    ) u_win_spad (
        .clk   (clk),
        .we    (win_we),
        .waddr (win_waddr),
        .wdata (if_data),
        .raddr (win_raddr),
        .rdata (win_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s_reg <= '0;
            e_rem <= '0;
            cnt   <= '0;
            head  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            s_reg <= s_n;
            e_rem <= e_n;
            cnt   <= cnt_n;
            head  <= head_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_reg;
        e_n     = e_rem;
        cnt_n   = cnt;
        head_n  = head;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((s_clamp == '0) || (cfg_e == '0)) begin
                        done_n = 1'b1;
                    end else begin
                        s_n     = s_clamp;
                        e_n     = cfg_e;
                        cnt_n   = '0;
                        state_n = LOAD_F;
                    end
                end
            end
            LOAD_F: begin
                if (flt_valid) begin
                    if (last_tap) begin
                        cnt_n   = '0;
                        state_n = LOAD_I;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            LOAD_I: begin
                if (if_valid) begin
                    if (last_tap) begin
                        cnt_n   = '0;
                        head_n  = '0;
                        state_n = MAC;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            MAC: begin
                if (last_tap) begin
                    cnt_n   = '0;
                    state_n = OUT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            OUT: begin
                if (ps_ready) begin
                    e_n = e_rem - 1'b1;
                    if (e_rem == E_W'(1)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SLIDE;
                    end
                end
            end
            SLIDE: begin
                if (if_valid) begin
                    head_n  = last_head() ? '0 : head + 1'b1;
                    state_n = MAC;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    function automatic logic last_head();
        return head == PW'(s_reg - 1'b1);
    endfunction

    assign busy       = (state != IDLE);
    assign flt_ready  = (state == LOAD_F);
    assign if_ready   = (state == LOAD_I) || (state == SLIDE);
    assign ps_valid   = (state == OUT);
    assign pe_en      = (state == MAC);
    assign pe_filter  = pe_en ? flt_rd : '0;
    assign pe_ifmap   = pe_en ? win_rd : '0;
    assign pe_psum_in = (pe_en && (cnt != '0)) ? pe_psum : '0;
    assign ps_data    = pe_psum;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
module tb_pe_seq_ctrl;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [4:0]      cfg_s;
    logic [7:0]      cfg_e;
    logic            busy, done;
    logic            flt_valid, flt_ready;
    logic [DW-1:0]   flt_data;
    logic            if_valid, if_ready;
    logic [DW-1:0]   if_data;
    logic            pe_en;
    logic [DW-1:0]   pe_ifmap, pe_filter, pe_psum_in, pe_psum;
    logic            ps_valid, ps_ready;
    logic [DW-1:0]   ps_data;
    logic [31:0]     prod;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pe_seq_ctrl #(
        .DATA_W (16),
        .MAX_S  (16),
        .E_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_s      (cfg_s),
        .cfg_e      (cfg_e),
        .busy       (busy),
        .done       (done),
        .flt_valid  (flt_valid),
        .flt_ready  (flt_ready),
        .flt_data   (flt_data),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_data    (if_data),
        .pe_en      (pe_en),
        .pe_ifmap   (pe_ifmap),
        .pe_filter  (pe_filter),
        .pe_psum_in (pe_psum_in),
        .pe_psum    (pe_psum),
        .ps_valid   (ps_valid),
        .ps_ready   (ps_ready),
        .ps_data    (ps_data)
    );

    // Behavioural PE: registered psum_in + low bits of the product.
    assign prod = pe_ifmap * pe_filter;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_psum <= '0;
        else if (pe_en) pe_psum <= pe_psum_in + prod[DW-1:0];
    end

    typedef struct {
        int                   s;
        int                   e;
        logic [3:0][DW-1:0]   f;
        logic [7:0][DW-1:0]   x;
        logic [3:0][DW-1:0]   r;
        int                   stall_at;
        bit                   restart;
    } job_t;

    job_t jobs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input job_t j, input string tag);
        int fi = 0, xi = 0, ri = 0, pe_cnt = 0, stall = 0, bad = 0, sbad = 0, early = 0;
        bit fin = 0;
        bit last = 0;
        logic [DW-1:0] held = '0;
        @(negedge clk);
        start = 1'b1; cfg_s = 5'(j.s); cfg_e = 8'(j.e);
        flt_valid = 1'b1; if_valid = 1'b1; ps_ready = 1'b1;
        flt_data = j.f[0]; if_data = j.x[0];
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_flt_ready_after_start"}, 32'(flt_ready), 32'd1);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (pe_en) pe_cnt++;
            else if ((pe_ifmap | pe_filter | pe_psum_in) != '0) bad++;
            if (done) early++;
            if (j.restart && cyc == 2) begin
                start = 1'b1; cfg_s = 5'd1; cfg_e = 8'd0;
            end else begin
                start = 1'b0;
            end
            if (fi < 4) flt_data = j.f[fi];
            if (xi < 8) if_data = j.x[xi];
            if (flt_ready) fi++;
            if (if_ready) xi++;
            ps_ready = 1'b1;
            if (ps_valid) begin
                if (ri == j.stall_at && stall < 5) begin
                    if (stall == 0) held = ps_data;
                    else if (ps_data !== held) sbad++;
                    if (pe_en || if_ready) sbad++;
                    ps_ready = 1'b0;
                    stall++;
                end else begin
                    chk($sformatf("%s_result%0d", tag, ri), 32'(ps_data), 32'(j.r[ri]));
                    ri++;
                    if (ri == j.e) last = 1;
                end
            end
            @(negedge clk);
            if (last) begin
                chk({tag, "_done_pulse"}, 32'(done), 32'd1);
                chk({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
                fin = 1;
            end
        end
        chk({tag, "_finished_in_budget"}, 32'(fin), 32'd1);
        ps_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_pe_en_cycles"}, 32'(pe_cnt), 32'(j.s * j.e));
        chk({tag, "_ifmap_transfers"}, 32'(xi), 32'(j.s + j.e - 1));
        chk({tag, "_filter_transfers"}, 32'(fi), 32'(j.s));
        chk({tag, "_idle_operands_zero"}, 32'(bad), 32'd0);
        chk({tag, "_early_done"}, 32'(early), 32'd0);
        if (j.stall_at >= 0) begin
            chk({tag, "_stall_cycles"}, 32'(stall), 32'd5);
            chk({tag, "_stall_hold"}, 32'(sbad), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int zbad;
        int pe_seen;
        bit hit;

        jobs[0] = '{s: 3, e: 1, stall_at: -1, restart: 0,
                    f: {16'h0, 16'd3, 16'd2, 16'd1},
                    x: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd6, 16'd5, 16'd4},
                    r: {16'h0, 16'h0, 16'h0, 16'd32}};
        jobs[1] = '{s: 3, e: 3, stall_at: -1, restart: 1,
                    f: {16'h0, 16'hFFFF, 16'h0, 16'd1},
                    x: {16'h0, 16'h0, 16'h0, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                    r: {16'h0, 16'hFFFE, 16'hFFFE, 16'hFFFE}};
        jobs[2] = '{s: 1, e: 1, stall_at: -1, restart: 0,
                    f: {16'h0, 16'h0, 16'h0, 16'h0100},
                    x: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100},
                    r: {16'h0, 16'h0, 16'h0, 16'h0000}};
        jobs[3] = '{s: 2, e: 2, stall_at: 0, restart: 0,
                    f: {16'h0, 16'h0, 16'd3, 16'd2},
                    x: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd3, 16'd2, 16'd1},
                    r: {16'h0, 16'h0, 16'd13, 16'd8}};
        jobs[4] = '{s: 2, e: 1, stall_at: -1, restart: 0,
                    f: {16'h0, 16'h0, 16'd3, 16'd2},
                    x: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'd7, 16'd5},
                    r: {16'h0, 16'h0, 16'h0, 16'd31}};

        rst_n = 1'b0; start = 1'b0; cfg_s = '0; cfg_e = '0;
        flt_valid = 1'b0; flt_data = '0; if_valid = 1'b0; if_data = '0; ps_ready = 1'b0;
        #12;
        chk("reset_ctrl_outputs", 32'({busy, done, flt_ready, if_ready, pe_en, ps_valid}), 32'd0);
        chk("reset_pe_operands", 32'(pe_filter | pe_ifmap | pe_psum_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_job(jobs[i], $sformatf("job%0d", i));
        end

        // Degenerate jobs: E=0 then S=0 finish with no handshakes.
        for (int z = 0; z < 2; z++) begin
            @(negedge clk);
            start = 1'b1;
            cfg_s = (z == 0) ? 5'd3 : 5'd0;
            cfg_e = (z == 0) ? 8'd0 : 8'd2;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("zero%0d_done_next", z), 32'(done), 32'd1);
            chk($sformatf("zero%0d_busy", z), 32'(busy), 32'd0);
            zbad = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (flt_ready || if_ready || busy || done) zbad++;
            end
            chk($sformatf("zero%0d_no_handshake", z), 32'(zbad), 32'd0);
        end

        // Reset asserted in the third MAC cycle of an S=4 job.
        @(negedge clk);
        start = 1'b1; cfg_s = 5'd4; cfg_e = 8'd1;
        flt_valid = 1'b1; if_valid = 1'b1; ps_ready = 1'b1;
        flt_data = 16'd1; if_data = 16'd1;
        @(negedge clk);
        start = 1'b0;
        pe_seen = 0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (pe_en) begin
                if (pe_seen == 2) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_mac_ctrl_outputs", 32'({busy, done, flt_ready, if_ready, pe_en, ps_valid}), 32'd0);
                    chk("rst_mac_pe_operands", 32'(pe_filter | pe_ifmap | pe_psum_in), 32'd0);
                    hit = 1;
                end
                pe_seen++;
            end
            if (!hit) @(negedge clk);
        end
        chk("rst_mac_reached", 32'(hit), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(jobs[4], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Sequencer for a single MAC processing element running a 1-D convolution row. It accepts a job (S filter taps, E outputs) and owns the filter and ifmap-window scratchpads. It streams operands into the PE one tap per cycle and feeds the PE's registered partial sum back as its next psum input. Each finished output is returned on a valid/ready port. It sits between the array-level data distributor and one PE instance.

## Interface
- DATA_W, 16: operand/psum width; matches PE datapath.
- MAX_S, 16: filter scratchpad depth (max taps); ifmap window depth.
- E_W, 8: width of output-count field.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- cfg_s  in  $clog2(MAX_S+1)  taps S, sampled with start.
- cfg_e  in  E_W  outputs E, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.
- flt_valid / flt_ready / flt_data  in / out / in DATA_W  filter stream.
- if_valid / if_ready / if_data  in / out / in DATA_W  ifmap stream.
- pe_en  out  1  PE accumulate enable.
- pe_ifmap, pe_filter, pe_psum_in  out  DATA_W  PE operands.
- pe_psum  in  DATA_W  PE registered result (output_psum).
- ps_valid / ps_ready / ps_data  out / in / out DATA_W  result stream.

## Operation
- States: IDLE, LOAD_F, LOAD_I, MAC, OUT, SLIDE.
- IDLE: on start, latch S = min(cfg_s, MAX_S) and E. If S==0 or E==0, pulse done next cycle, then return to IDLE with no handshakes. Otherwise go to LOAD_F.
- LOAD_F: flt_ready=1. Each transfer writes filter slot f (0..S-1). After the S-th transfer, go to LOAD_I.
- LOAD_I: if_ready=1. Each transfer writes window slot i. After S transfers, set head=0 and go to MAC.
- MAC: k = 0..S-1, one tap per cycle. Drive pe_en=1, pe_filter=filt[k], pe_ifmap=win[(head+k) mod S], and pe_psum_in = (k==0) ? 0 : pe_psum. After k==S-1, go to OUT.
- OUT: ps_valid=1 and ps_data=pe_psum. ps_data is stable because pe_en is 0. On a ps_ready transfer, decrement remaining E. If E reaches 0, pulse done and go to IDLE. Otherwise go to SLIDE.
- SLIDE: if_ready=1. On transfer, win[head] gets if_data, head = (head+1) mod S, then go to MAC.
- Arithmetic: the PE computes psum_in + low DATA_W bits of the product, modulo 2^DATA_W, with no saturation. The controller never modifies the data.
- A job consumes exactly S filter words and S+E-1 ifmap words.
- start while busy: ignored.
- Stalls: flt_valid, if_valid or ps_ready low holds the current state. pe_en stays 0 during any stall.
- When pe_en=0: pe_ifmap, pe_filter and pe_psum_in are 0.
- Reset (any time, including mid-MAC): state goes to IDLE immediately. busy, done, flt_ready, if_ready, pe_en, ps_valid and all counters/pointers go to 0. Scratchpad contents are don't-care.

## Timing
- Start accepted at edge t: busy=1 and flt_ready=1 from t+1.
- MAC is back-to-back: the PE result for tap k appears at the edge ending that cycle and is fed back as the psum input for tap k+1.
- First cycle of OUT: ps_data already equals the full S-tap sum. Zero-cycle bubble.
- Best-case per output: S MAC cycles + 1 OUT + 1 SLIDE. The last output has no SLIDE.
- done is asserted in the cycle after the final ps transfer edge. busy falls in the same cycle.
- All outputs are registered or decoded from registered state only. There are no combinational paths from valid/ready inputs to ready/valid outputs.

## Structure
- Package pe_pkg: DATA_W, MAX_S, E_W, derived pointer widths, and the state enum (IDLE..SLIDE).
- Sub-module pe_spad: MAX_S×DATA_W register file with 1 write port and 1 asynchronous read port. Instantiated twice, once for filter and once for the ifmap window.
- The FSM, tap/E counters and head pointer live in pe_seq_ctrl. The PE itself is instantiated outside this block.

## Test plan
- S=3, E=1, filter {1,2,3}, ifmap {4,5,6}, all valid/ready high → ps_data=32 (0x0020). done pulses one cycle after the ps transfer. Exactly 3 pe_en cycles.
- S=3, E=3, filter {1,0,0xFFFF}, ifmap {1,2,3,4,5} → three results of 0xFFFE. Exactly 5 ifmap transfers.
- Wrap: S=1, E=1, filter {0x0100}, ifmap {0x0100} → ps_data=0x0000.
- Backpressure: ps_ready low for 5 cycles in OUT → ps_valid held, ps_data constant, pe_en=0, if_ready=0. The job resumes correctly after the stall.
- Reset mid-MAC (S=4, assert rst_n at k=2) → all outputs are 0 asynchronously. A following S=2 job with filter {2,3} and ifmap {5,7} gives 31.
- cfg_e=0 → done pulses the next cycle, flt_ready and if_ready are never asserted. A start issued while busy has no effect.
